// File: rtl/cpu_defs.sv
// Shared sequencer state encodings, opcode constants and decode helpers.
package cpu_defs;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_F0    = 4'd1,
    ST_F1    = 4'd2,
    ST_F2    = 4'd3,
    ST_DEC   = 4'd4,
    ST_EXEC  = 4'd5,
    ST_BR    = 4'd6,
    ST_JR    = 4'd7,
    ST_HALT  = 4'd8,
    ST_FAULT = 4'd9
  } seq_state_e;

  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [4:0] OP_NOP  = 5'b11010;

  function automatic seq_state_e decode_target(input logic [4:0] op);
    seq_state_e target;
    case (op)
      OP_BR:   target = ST_BR;
      OP_JR:   target = ST_JR;
      OP_HALT: target = ST_HALT;
      OP_NOP:  target = ST_F0;
      default: target = ST_EXEC;
    endcase
    return target;
  endfunction

  // A finished instruction only starts the next fetch while run is still high.
  function automatic seq_state_e after_instr(input logic run);
    return run ? ST_F0 : ST_IDLE;
  endfunction

endpackage

// File: rtl/pc_sequencer_wait_timer.sv
// Saturating memory-wait counter; limit_o flags that one more miss reaches LIMIT.
module wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic inc_i,
  output logic limit_o
);
  localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] SAT  = W'(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != SAT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign limit_o = (count_q >= LAST);
endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch/decode sequencer: PC->MAR, memory read into IR, then dispatch
// to execute, branch, jump or halt; a stalled memory read ends in FAULT.
module pc_sequencer
  import cpu_defs::*;
#(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic [4:0] opcode,
  input  logic       conOut,
  input  logic       mem_ready,
  input  logic       exec_done,
  output logic       IncPC,
  output logic       PC_enable,
  output logic       PCout,
  output logic       MARin,
  output logic       Read,
  output logic       MDRin,
  output logic       IRin,
  output logic       exec_start,
  output logic       halted,
  output logic       fault,
  output logic [3:0] state
);
  seq_state_e state_q, state_d;
  logic       exec_first_q, exec_first_d;
  logic       pc_en_q, pc_en_d;
  logic       timer_clear, timer_inc, timer_limit;

  wait_timer #(
    .LIMIT(WAIT_LIMIT)
  ) u_wait_timer (
    .clock  (clock),
    .reset  (reset),
    .clear_i(timer_clear),
    .inc_i  (timer_inc),
    .limit_o(timer_limit)
  );

  always_comb begin
    state_d     = state_q;
    timer_clear = 1'b0;
    timer_inc   = 1'b0;
    case (state_q)
      ST_IDLE:  if (run) state_d = ST_F0;
      ST_F0: begin
        state_d     = ST_F1;
        timer_clear = 1'b1;
      end
      ST_F1: begin
        if (mem_ready) begin
          state_d = ST_F2;
        end else begin
          timer_inc = 1'b1;
          if (timer_limit) state_d = ST_FAULT;
        end
      end
      ST_F2:    state_d = ST_DEC;
      ST_DEC:   state_d = decode_target(opcode);
      ST_EXEC:  if (exec_done) state_d = after_instr(run);
      ST_BR,
      ST_JR:    state_d = after_instr(run);
      ST_HALT,
      ST_FAULT: state_d = state_q;
      default:  state_d = ST_IDLE;
    endcase
    // One-shot qualifiers are registered alongside the state so strobes stay Moore.
    exec_first_d = (state_q == ST_DEC) && (state_d == ST_EXEC);
    pc_en_d      = (state_q == ST_DEC) &&
                   ((state_d == ST_JR) || ((state_d == ST_BR) && conOut));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      exec_first_q <= 1'b0;
      pc_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      exec_first_q <= exec_first_d;
      pc_en_q      <= pc_en_d;
    end
  end

  assign PCout      = (state_q == ST_F0);
  assign MARin      = (state_q == ST_F0);
  assign IncPC      = (state_q == ST_F0);
  assign Read       = (state_q == ST_F1);
  assign MDRin      = (state_q == ST_F1);
  assign IRin       = (state_q == ST_F2);
  assign exec_start = exec_first_q && (state_q == ST_EXEC);
  assign PC_enable  = pc_en_q && ((state_q == ST_BR) || (state_q == ST_JR));
  assign halted     = (state_q == ST_HALT);
  assign fault      = (state_q == ST_FAULT);
  assign state      = state_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Event-level scoreboard bench: instruction lists are turned into expected strobe
// events with cycle gaps; a monitor matches them against what the DUT emits.
module tb_pc_sequencer;
  localparam int WL = 4;
  localparam logic [4:0] T_BR = 5'b10010, T_JR = 5'b10011, T_HALT = 5'b11011, T_NOP = 5'b11010;
  localparam int EV_FETCH = 0, EV_IR = 1, EV_EXEC = 2, EV_JUMP = 3, EV_HALT = 4, EV_FAULT = 5;

  typedef struct packed { int kind; int delta; } exp_t;
  typedef struct packed { logic [4:0] op; logic con; int n; int m; } instr_t;

  logic clock = 1'b0, reset = 1'b1, run = 1'b0, conOut = 1'b0, mem_ready = 1'b0, exec_done = 1'b0;
  logic [4:0] opcode = 5'd0;
  logic IncPC, PC_enable, PCout, MARin, Read, MDRin, IRin, exec_start, halted, fault;
  logic [3:0] state;

  exp_t   exp_q[$];
  instr_t seg_q[$];
  int total = 0, bad = 0, cyc = 0, last_ev = 0, fetch_seen = 0, fetch_expected = 0;
  logic halted_prev = 1'b0, fault_prev = 1'b0;

  pc_sequencer #(.WAIT_LIMIT(WL)) dut (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode), .conOut(conOut),
    .mem_ready(mem_ready), .exec_done(exec_done), .IncPC(IncPC), .PC_enable(PC_enable),
    .PCout(PCout), .MARin(MARin), .Read(Read), .MDRin(MDRin), .IRin(IRin),
    .exec_start(exec_start), .halted(halted), .fault(fault), .state(state)
  );

  always #5 clock = ~clock;

  function automatic int outs();
    return int'({IncPC, PC_enable, PCout, MARin, Read, MDRin, IRin, exec_start, halted, fault});
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int kind, input int delta);
    exp_t e;
    e.kind = kind;
    e.delta = delta;
    exp_q.push_back(e);
    if (kind == EV_FETCH) fetch_expected++;
  endtask

  task automatic observe(input int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d, expected none (cycle %0d)", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (e.delta >= 0) check("event_gap", cyc - last_ev, e.delta);
    end
    last_ev = cyc;
  endtask

  // Monitor: every strobe pulse is one event popped from the scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      total++;
      assert (!(IncPC && PC_enable))
      else begin
        bad++;
        $display("FAIL incpc_pcenable_overlap: got both high, expected exclusive (cycle %0d)", cyc);
      end
      if (IncPC === 1'b1) begin
        fetch_seen++;
        check("fetch_strobes", int'({PCout, MARin}), 3);
        observe(EV_FETCH);
      end
      if (IRin === 1'b1) observe(EV_IR);
      if (exec_start === 1'b1) observe(EV_EXEC);
      if (PC_enable === 1'b1) observe(EV_JUMP);
      if (halted === 1'b1 && !halted_prev) observe(EV_HALT);
      if (fault === 1'b1 && !fault_prev) observe(EV_FAULT);
      halted_prev = (halted === 1'b1);
      fault_prev  = (fault === 1'b1);
    end
  end

  // Reference model: expected events and gaps from the instruction-level timing rules.
  task automatic push_segment();
    int fd = -1;
    foreach (seg_q[i]) begin
      push(EV_FETCH, fd);
      push(EV_IR, 2 + seg_q[i].n);
      if (seg_q[i].op == T_BR) begin
        if (seg_q[i].con) begin push(EV_JUMP, 2); fd = 1; end
        else fd = 3;
      end else if (seg_q[i].op == T_JR) begin
        push(EV_JUMP, 2); fd = 1;
      end else if (seg_q[i].op == T_HALT) begin
        push(EV_HALT, 2); fd = -1;
      end else if (seg_q[i].op == T_NOP) begin
        fd = 2;
      end else begin
        push(EV_EXEC, 2); fd = seg_q[i].m + 1;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; mem_ready = 1'b0; exec_done = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("reset_state", int'(state), 0);
    check("reset_outputs", outs(), 0);
    @(negedge clock);
    check("idle_without_run", int'(state), 0);
    check("first_cycle_outputs", outs(), 0);
  endtask

  task automatic wait_read();
    int k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (Read !== 1'b1 && k < 30);
    if (Read !== 1'b1) check("read_timeout", 0, 1);
  endtask

  task automatic drive_instr(input instr_t ins);
    opcode = ins.op;
    conOut = ins.con;
    wait_read();
    repeat (ins.n) @(negedge clock);
    mem_ready = 1'b1;
    @(negedge clock);
    mem_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    if (ins.op != T_BR && ins.op != T_JR && ins.op != T_HALT && ins.op != T_NOP) begin
      repeat (ins.m) @(negedge clock);
      exec_done = 1'b1;
      @(negedge clock);
      exec_done = 1'b0;
    end
  endtask

  task automatic run_segment();
    int ok = 0;
    do_reset();
    push_segment();
    run = 1'b1;
    foreach (seg_q[i]) drive_instr(seg_q[i]);
    repeat (20) begin
      @(negedge clock);
      if (state == 4'd8 && halted === 1'b1) ok++;
    end
    check("halt_hold_20", ok, 20);
    seg_q.delete();
  endtask

  function automatic instr_t mk(input logic [4:0] op, input logic con, input int n, input int m);
    instr_t r;
    r.op = op; r.con = con; r.n = n; r.m = m;
    return r;
  endfunction

  initial begin
    instr_t ins;
    logic [4:0] op;
    int fetch_mark;

    // Fetch with one wait, execute finishing on its third cycle, then halt.
    seg_q.push_back(mk(5'b00011, 1'b0, 1, 2));
    seg_q.push_back(mk(T_HALT, 1'b0, 0, 0));
    run_segment();
    // Branch taken, branch not taken, jump, nop, mem_ready on the limit cycle.
    seg_q.push_back(mk(T_BR, 1'b1, 0, 0));
    seg_q.push_back(mk(T_BR, 1'b0, 2, 0));
    seg_q.push_back(mk(T_JR, 1'b0, 0, 0));
    seg_q.push_back(mk(T_NOP, 1'b0, 1, 0));
    seg_q.push_back(mk(5'b00000, 1'b0, WL - 1, 0));
    seg_q.push_back(mk(T_HALT, 1'b0, 0, 0));
    run_segment();

    // Memory never ready: FAULT after WL wait cycles, sticky until reset.
    do_reset();
    push(EV_FETCH, -1);
    push(EV_FAULT, WL + 1);
    opcode = 5'd0;
    run = 1'b1;
    wait_read();
    repeat (WL) @(negedge clock);
    check("fault_state", int'(state), 9);
    check("fault_outputs", outs(), 1);
    mem_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("fault_sticky", int'(state), 9);

    // Reset while waiting in F1.
    do_reset();
    push(EV_FETCH, -1);
    run = 1'b1;
    wait_read();
    reset = 1'b1;
    @(negedge clock);
    check("reset_in_f1_state", int'(state), 0);
    check("reset_in_f1_outputs", outs(), 0);

    // Reset during EXEC.
    do_reset();
    push(EV_FETCH, -1); push(EV_IR, 2); push(EV_EXEC, 2);
    opcode = 5'b00101;
    run = 1'b1;
    wait_read();
    mem_ready = 1'b1;
    @(negedge clock);
    mem_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("reset_in_exec_state", int'(state), 0);
    check("reset_in_exec_outputs", outs(), 0);

    // run drops mid-instruction: the instruction completes, then IDLE.
    do_reset();
    push(EV_FETCH, -1); push(EV_IR, 2); push(EV_EXEC, 2);
    opcode = 5'b00101;
    run = 1'b1;
    wait_read();
    mem_ready = 1'b1;
    @(negedge clock);
    mem_ready = 1'b0;
    repeat (2) @(negedge clock);
    run = 1'b0;
    fetch_mark = fetch_seen;
    repeat (2) @(negedge clock);
    exec_done = 1'b1;
    @(negedge clock);
    exec_done = 1'b0;
    check("run_drop_idle", int'(state), 0);
    repeat (3) @(negedge clock);
    check("run_drop_no_fetch", fetch_seen - fetch_mark, 0);

    // Random instruction streams, each closed by a halt.
    for (int s = 0; s < 10; s++) begin
      for (int i = 0; i < int'($urandom_range(8, 15)); i++) begin
        case ($urandom_range(0, 5))
          0: op = T_BR;
          1: op = T_JR;
          2: op = T_NOP;
          default: op = 5'($urandom);
        endcase
        if (op == T_HALT) op = T_NOP;
        ins = mk(op, 1'($urandom), int'($urandom_range(0, WL - 1)), int'($urandom_range(0, 4)));
        seg_q.push_back(ins);
      end
      seg_q.push_back(mk(T_HALT, 1'b0, 0, 0));
      run_segment();
    end

    do_reset();
    repeat (2) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 0);
    check("incpc_vs_f0_entries", fetch_seen, fetch_expected);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 15: maximum cycles spent waiting for mem_ready before a fault.
REQ-002 SHALL have port clock, input, 1: single system clock; all state updates on posedge.
REQ-003 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port run, input, 1: allows leaving IDLE to start a fetch.
REQ-005 SHALL have port opcode, input, 5: IR[31:27], valid from the cycle after IRin.
REQ-006 SHALL have port conOut, input, 1: branch condition from the CON FF logic.
REQ-007 SHALL have port mem_ready, input, 1: memory read data valid.
REQ-008 SHALL have port exec_done, input, 1: execute sequencer finished.
REQ-009 SHALL have outputs IncPC, PC_enable, PCout, MARin, Read, MDRin, IRin, exec_start, each 1 bit: datapath strobes.
REQ-010 SHALL have outputs halted and fault, each 1 bit: status flags.
REQ-011 SHALL have output state, 4 bits: current state encoding, for debug.

Function
REQ-012 SHALL have states IDLE, F0, F1, F2, DEC, EXEC, BR, JR, HALT and FAULT.
REQ-013 SHALL decode all outputs purely from the state register (Moore), so every strobe is stable for the whole cycle.
REQ-014 IDLE SHALL assert no strobes, SHALL move to F0 when run=1, and SHALL stay in IDLE otherwise.
REQ-015 F0 SHALL assert PCout, MARin and IncPC for exactly one cycle, then move to F1.
REQ-016 F1 SHALL assert Read and MDRin, SHALL stay in F1 until mem_ready=1, then move to F2.
REQ-017 F2 SHALL assert IRin for one cycle, then move to DEC.
REQ-018 DEC SHALL assert no strobes and SHALL branch on opcode:
- 5'b10010 -> BR
- 5'b10011 -> JR
- 5'b11011 -> HALT
- 5'b11010 (nop) -> F0
- all others -> EXEC
REQ-019 EXEC SHALL assert exec_start on its first cycle only, SHALL hold until exec_done=1, then move to F0.
REQ-020 BR SHALL assert PC_enable for one cycle only when conOut=1, and SHALL move to F0 in either case.
REQ-021 JR SHALL assert PC_enable unconditionally for one cycle, then move to F0.
REQ-022 IncPC and PC_enable SHALL never be asserted in the same cycle.
REQ-023 HALT SHALL assert halted and SHALL stay in HALT until reset; run SHALL be ignored there.
REQ-024 A wait counter SHALL clear on entry to F1 and increment on each F1 cycle with mem_ready=0.
REQ-025 When the wait counter reaches WAIT_LIMIT with mem_ready=0, the block SHALL move to FAULT instead of staying in F1.
REQ-026 FAULT SHALL assert fault, SHALL assert no strobes, and SHALL stay in FAULT until reset.
REQ-027 If mem_ready=1 arrives on the same cycle the limit is hit, mem_ready SHALL win and the block SHALL go to F2.
REQ-028 run falling to 0 SHALL take effect only from F0 entry: the current instruction completes, then the block returns to IDLE instead of F0.
REQ-029 The wait counter SHALL be ceil(log2(WAIT_LIMIT+1)) bits wide and SHALL saturate, never wrap.

Reset
REQ-030 reset=1 at a posedge SHALL force IDLE, clear the wait counter, and deassert every output, including halted and fault.
REQ-031 reset SHALL take priority over every transition, including mid-fetch, mid-EXEC, HALT and FAULT.
REQ-032 Outputs SHALL be 0 in the first cycle after reset deasserts.

Structure
REQ-033 The state encodings and opcode constants (OP_BR, OP_JR, OP_HALT, OP_NOP) SHALL live in the shared cpu_defs package.
REQ-034 The wait counter SHALL be implemented as one sub-module, wait_timer (clear, inc, limit reached), instantiated once.

Verification
REQ-035 Reset, then run=1, opcode=5'b00011, mem_ready on the 2nd F1 cycle, exec_done after 3 cycles -> IncPC high exactly 1 cycle, exec_start 1 cycle, return to F0.
REQ-036 opcode=5'b10010 with conOut=1, then with conOut=0 -> PC_enable pulses once in the first case and is never asserted in the second.
REQ-037 opcode=5'b11011 -> halted=1 held through 20 cycles of run=1; reset -> IDLE with halted=0.
REQ-038 mem_ready held 0 with WAIT_LIMIT=4 -> FAULT entered after 4 F1 wait cycles, fault=1; mem_ready=1 on the 4th cycle instead -> F2.
REQ-039 reset asserted in F1 and in EXEC -> IDLE on the next posedge, all strobes 0.
REQ-040 Over a random opcode stream, run for 1000 cycles -> assertion that IncPC and PC_enable are never both high, and IncPC count equals the F0 entry count.
